// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin, burst-capable arbiter that shares one synchronous FIFO write
// port among NUM_REQ producers. A producer that wins the grant keeps it for up
// to MAX_BURST transfers. Stall cycles do not count toward that limit. The
// grant is released early if the owner drops req_valid.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   req_valid       : [NUM_REQ]            per-producer valid
//   req_data        : [NUM_REQ*FIFO_WIDTH] producer i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   req_ready       : [NUM_REQ]            one-hot or zero; transfer = valid & ready
//   fifo_full       : FIFO full flag, used as back-pressure
//   fifo_overflow   : FIFO overflow flag, captured into overflow_err
//   fifo_wr_en      : FIFO write enable; never high while fifo_full is high
//   fifo_data_in    : FIFO write data; zero whenever fifo_wr_en is low
//   clr_err         : synchronous clear of overflow_err (set wins)
//   busy            : high while a burst grant is held
//   owner_id        : current owner; meaningful while busy is high
//   xfer_total      : accepted transfers, wraps modulo 2^16
//   stall_cycles    : cycles with a pending requester blocked by fifo_full,
//                     saturates at 16'hFFFF
//   overflow_err    : sticky overflow indication
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          clr_err,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic [15:0]                   xfer_total,
  output logic [15:0]                   stall_cycles,
  output logic                          overflow_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = 4;  // holds MAX_BURST up to 15

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            cand_found;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] sel_id;
  logic            xfer;
  logic            stall;

  // Next requester index, wrapping at NUM_REQ (which need not be a power of 2).
  function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) return '0;
    return id + ID_W'(1);
  endfunction

  // First valid requester, searching upward from rr_q with wrap-around.
  always_comb begin
    int idx;
    cand_found = 1'b0;
    cand       = '0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!cand_found && req_valid[idx]) begin
        cand_found = 1'b1;
        cand       = ID_W'(idx);
      end
    end
  end

  // Next-state and handshake outputs.
  // NOTE: every signal written here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    xfer      = 1'b0;
    stall     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cand_found) begin
          if (!fifo_full) begin
            req_ready[cand] = 1'b1;
            xfer            = 1'b1;
            if (MAX_BURST == 1) begin
              rr_d = inc_id(cand);
            end else begin
              state_d = BUSY;
              owner_d = cand;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            stall = 1'b1;
          end
        end
      end

      BUSY: begin
        // The owner sees ready even if it is not valid. That cycle still
        // releases the grant without a transfer.
        req_ready[owner_q] = !fifo_full;
        if (!req_valid[owner_q]) begin
          state_d = IDLE;
          rr_d    = inc_id(owner_q);
        end else if (fifo_full) begin
          stall = 1'b1;
        end else begin
          xfer  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (int'(cnt_q) + 1 == MAX_BURST) begin
            state_d = IDLE;
            rr_d    = inc_id(owner_q);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Handshake outputs stay quiet for as long as reset is held. This also
    // covers the window in which the registers have already cleared.
    if (!rst_n) req_ready = '0;
  end

  assign sel_id       = (state_q == BUSY) ? owner_q : cand;
  assign fifo_wr_en   = xfer & rst_n;
  assign fifo_data_in = fifo_wr_en ? req_data[int'(sel_id)*FIFO_WIDTH +: FIFO_WIDTH]
                                   : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      xfer_total   <= '0;
      stall_cycles <= '0;
      overflow_err <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (xfer) xfer_total <= xfer_total + 16'd1;
      if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      // A new overflow takes priority over a clear in the same cycle.
      if (fifo_overflow)  overflow_err <= 1'b1;
      else if (clr_err)   overflow_err <= 1'b0;
    end
  end

  assign busy     = (state_q == BUSY);
  assign owner_id = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, FIFO_WIDTH=16,
// MAX_BURST=4). A transaction-level model tracks grant ownership, burst
// length, the round-robin pointer and counters as plain integers. It predicts
// the combinational handshake and the registered status for every cycle.
// Inputs change 1 ns after a rising edge. Outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int MB   = 4;
  localparam int ID_W = $clog2(N);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N*W-1:0]     req_data;
  logic [N-1:0]       req_ready;
  logic               fifo_full;
  logic               fifo_overflow;
  logic               fifo_wr_en;
  logic [W-1:0]       fifo_data_in;
  logic               clr_err;
  logic               busy;
  logic [ID_W-1:0]    owner_id;
  logic [15:0]        xfer_total;
  logic [15:0]        stall_cycles;
  logic               overflow_err;

  int n_checks = 0;
  int n_errors = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_overflow(fifo_overflow),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .clr_err      (clr_err),
    .busy         (busy),
    .owner_id     (owner_id),
    .xfer_total   (xfer_total),
    .stall_cycles (stall_cycles),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit     m_busy;
  int     m_owner, m_cnt, m_rr, m_xfer, m_stall;
  bit     m_err;
  bit     m_found;
  int     m_cand;
  logic [N-1:0] e_ready;
  logic         e_wr;
  logic [W-1:0] e_data;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
    m_xfer = 0; m_stall = 0; m_err = 0;
  endtask

  // Expected handshake for the inputs currently applied.
  task automatic model_comb();
    e_ready = '0; e_wr = 1'b0; e_data = '0; m_found = 0; m_cand = 0;
    if (rst_n !== 1'b1) return;
    if (m_busy) begin
      e_ready[m_owner] = !fifo_full;
      e_wr = req_valid[m_owner] && !fifo_full;
      if (e_wr) e_data = req_data[m_owner*W +: W];
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (!m_found && req_valid[i]) begin
          m_found = 1;
          m_cand  = i;
        end
      end
      if (m_found && !fifo_full) begin
        e_ready[m_cand] = 1'b1;
        e_wr   = 1'b1;
        e_data = req_data[m_cand*W +: W];
      end
    end
  endtask

  // Advance the model across one rising edge. It uses the same inputs and
  // the prediction made by model_comb.
  task automatic model_tick();
    if (rst_n !== 1'b1) begin
      model_reset();
      return;
    end
    if (fifo_full && (m_busy ? req_valid[m_owner] : m_found))
      if (m_stall < 65535) m_stall++;
    if (e_wr) m_xfer = (m_xfer + 1) % 65536;
    if (fifo_overflow) m_err = 1;
    else if (clr_err)  m_err = 0;
    if (!m_busy) begin
      if (e_wr) begin
        if (MB == 1) m_rr = (m_cand + 1) % N;
        else begin
          m_busy = 1; m_owner = m_cand; m_cnt = 1;
        end
      end
    end else if (!req_valid[m_owner]) begin
      m_busy = 0; m_rr = (m_owner + 1) % N;
    end else if (e_wr) begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_busy = 0; m_rr = (m_owner + 1) % N;
      end
    end
  endtask

  function automatic logic [ID_W+33:0] exp_regs();
    return {m_busy, (m_busy ? ID_W'(m_owner) : ID_W'(0)), 16'(m_xfer), 16'(m_stall), m_err};
  endfunction

  function automatic logic [ID_W+33:0] act_regs();
    return {busy, (busy ? owner_id : ID_W'(0)), xfer_total, stall_cycles, overflow_err};
  endfunction

  function automatic int granted_id();
    for (int i = 0; i < N; i++) if (req_ready[i]) return i;
    return -1;
  endfunction

  task automatic eval_cycle();
    @(negedge clk);
    model_comb();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; fifo_full = 1'b0;
    fifo_overflow = 1'b0; clr_err = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1; req_data = {$urandom, $urandom};
    fifo_full = 1'b0; fifo_overflow = 1'b0; clr_err = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({req_ready, fifo_wr_en, fifo_data_in, busy, owner_id, xfer_total, stall_cycles, overflow_err} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: ready=%b wr=%b data=%h busy=%b owner=%0d xfer=%0d stall=%0d err=%b, all required 0",
               req_ready, fifo_wr_en, fifo_data_in, busy, owner_id, xfer_total, stall_cycles, overflow_err);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_single();
    int wr_seen;
    apply_reset();
    wr_seen = 0;
    req_valid = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      req_data = {$urandom, $urandom};
      req_data[2*W +: W] = 16'hA5A5;
      eval_cycle();
      n_checks++;
      if ({req_ready, fifo_wr_en, fifo_data_in} !== {e_ready, e_wr, e_data}) begin
        n_errors++;
        $display("FAIL single_comb t=%0t: ready=%b wr=%b data=%h, required ready=%b wr=%b data=%h",
                 $time, req_ready, fifo_wr_en, fifo_data_in, e_ready, e_wr, e_data);
      end
      n_checks++;
      if (act_regs() !== exp_regs()) begin
        n_errors++;
        $display("FAIL single_regs t=%0t: got %h required %h", $time, act_regs(), exp_regs());
      end
      if (fifo_wr_en === 1'b1) wr_seen++;
      n_checks++;
      if (fifo_data_in !== 16'hA5A5) begin
        n_errors++;
        $display("FAIL single_data t=%0t: data=%h required a5a5", $time, fifo_data_in);
      end
      tick();
    end
    eval_cycle();
    n_checks++;
    if (xfer_total !== 16'd10 || wr_seen != 10) begin
      n_errors++;
      $display("FAIL single_total: xfer_total=%0d writes=%0d, required 10 and 10", xfer_total, wr_seen);
    end
    n_checks++;
    if (busy !== 1'b1 || owner_id !== ID_W'(2)) begin
      n_errors++;
      $display("FAIL single_owner: busy=%b owner=%0d, required busy=1 owner=2", busy, owner_id);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
    apply_reset();
    req_valid = '1;
    for (int c = 0; c < 17; c++) begin
      req_data = {$urandom, $urandom};
      eval_cycle();
      n_checks++;
      if ({req_ready, fifo_wr_en, fifo_data_in} !== {e_ready, e_wr, e_data}) begin
        n_errors++;
        $display("FAIL rr_comb t=%0t: ready=%b wr=%b data=%h, required ready=%b wr=%b data=%h",
                 $time, req_ready, fifo_wr_en, fifo_data_in, e_ready, e_wr, e_data);
      end
      n_checks++;
      if (act_regs() !== exp_regs()) begin
        n_errors++;
        $display("FAIL rr_regs t=%0t: got %h required %h", $time, act_regs(), exp_regs());
      end
      order.push_back(fifo_wr_en === 1'b1 ? granted_id() : -1);
      tick();
    end
    for (int i = 0; i < 17; i++) begin
      n_checks++;
      if (order[i] != exp_order[i]) begin
        n_errors++;
        $display("FAIL rr_order[%0d]: granted %0d required %0d", i, order[i], exp_order[i]);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_stall();
    int grants[$];
    apply_reset();
    req_valid = 4'b1010;
    // 2 transfers to owner 1, 5 full cycles, then 2 more transfers, then the
    // next grant must go to requester 3.
    for (int c = 0; c < 10; c++) begin
      req_data  = {$urandom, $urandom};
      fifo_full = (c >= 2 && c < 7);
      eval_cycle();
      n_checks++;
      if ({req_ready, fifo_wr_en, fifo_data_in} !== {e_ready, e_wr, e_data}) begin
        n_errors++;
        $display("FAIL stall_comb t=%0t: ready=%b wr=%b data=%h, required ready=%b wr=%b data=%h",
                 $time, req_ready, fifo_wr_en, fifo_data_in, e_ready, e_wr, e_data);
      end
      if (fifo_full) begin
        n_checks++;
        if (fifo_wr_en !== 1'b0 || req_ready !== '0 || busy !== 1'b1 || owner_id !== ID_W'(1)) begin
          n_errors++;
          $display("FAIL stall_hold t=%0t: wr=%b ready=%b busy=%b owner=%0d, required 0 0000 1 1",
                   $time, fifo_wr_en, req_ready, busy, owner_id);
        end
      end
      grants.push_back(fifo_wr_en === 1'b1 ? granted_id() : -1);
      tick();
    end
    eval_cycle();
    n_checks++;
    if (stall_cycles !== 16'd5 || xfer_total !== 16'd5) begin
      n_errors++;
      $display("FAIL stall_counts: stall=%0d xfer=%0d, required 5 and 5", stall_cycles, xfer_total);
    end
    n_checks++;
    if (grants[7] != 1 || grants[8] != 1 || grants[9] != 3) begin
      n_errors++;
      $display("FAIL stall_resume: grants %0d %0d %0d, required 1 1 3", grants[7], grants[8], grants[9]);
    end
    fifo_full = 1'b0;
    req_valid = '0;
    tick();
  endtask

  task automatic test_drop();
    apply_reset();
    req_data  = {$urandom, $urandom};
    req_valid = 4'b1000;
    eval_cycle();
    n_checks++;
    if (req_ready !== 4'b1000 || fifo_wr_en !== 1'b1) begin
      n_errors++;
      $display("FAIL drop_first: ready=%b wr=%b, required 1000 1", req_ready, fifo_wr_en);
    end
    tick();
    req_valid = 4'b0001;
    eval_cycle();
    n_checks++;
    if (fifo_wr_en !== 1'b0 || req_ready[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_idle: wr=%b ready=%b, required wr=0 ready[0]=0", fifo_wr_en, req_ready);
    end
    tick();
    eval_cycle();
    n_checks++;
    if (req_ready !== 4'b0001 || fifo_wr_en !== 1'b1 || fifo_data_in !== req_data[W-1:0]) begin
      n_errors++;
      $display("FAIL drop_next: ready=%b wr=%b data=%h, required 0001 1 %h",
               req_ready, fifo_wr_en, fifo_data_in, req_data[W-1:0]);
    end
    n_checks++;
    if (act_regs() !== exp_regs()) begin
      n_errors++;
      $display("FAIL drop_regs t=%0t: got %h required %h", $time, act_regs(), exp_regs());
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_mid_reset();
    apply_reset();
    req_valid = '1;
    req_data  = {$urandom, $urandom};
    fifo_overflow = 1'b1;
    for (int c = 0; c < 2; c++) begin
      eval_cycle();
      tick();
      fifo_overflow = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, fifo_wr_en, fifo_data_in, busy, owner_id, xfer_total, stall_cycles, overflow_err} !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs: ready=%b wr=%b data=%h busy=%b owner=%0d xfer=%0d stall=%0d err=%b, all required 0",
               req_ready, fifo_wr_en, fifo_data_in, busy, owner_id, xfer_total, stall_cycles, overflow_err);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    eval_cycle();
    n_checks++;
    if (req_ready !== 4'b0001 || fifo_wr_en !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_restart: ready=%b wr=%b, required 0001 1", req_ready, fifo_wr_en);
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_overflow();
    apply_reset();
    fifo_overflow = 1'b1;
    eval_cycle(); tick();
    fifo_overflow = 1'b0;
    eval_cycle();
    n_checks++;
    if (overflow_err !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_set: overflow_err=%b required 1", overflow_err);
    end
    tick();
    fifo_overflow = 1'b1; clr_err = 1'b1;
    eval_cycle(); tick();
    fifo_overflow = 1'b0; clr_err = 1'b0;
    eval_cycle();
    n_checks++;
    if (overflow_err !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_set_wins: overflow_err=%b required 1", overflow_err);
    end
    tick();
    clr_err = 1'b1;
    eval_cycle(); tick();
    clr_err = 1'b0;
    eval_cycle();
    n_checks++;
    if (overflow_err !== 1'b0 || act_regs() !== exp_regs()) begin
      n_errors++;
      $display("FAIL ovf_clear: overflow_err=%b regs %h, required 0 regs %h", overflow_err, act_regs(), exp_regs());
    end
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid     = N'($urandom);
      req_data      = {$urandom, $urandom};
      fifo_full     = ($urandom_range(0, 9) < 3);
      fifo_overflow = ($urandom_range(0, 19) == 0);
      clr_err       = ($urandom_range(0, 9) == 0);
      eval_cycle();
      n_checks++;
      if ({req_ready, fifo_wr_en, fifo_data_in} !== {e_ready, e_wr, e_data}) begin
        n_errors++;
        $display("FAIL random_comb t=%0t: ready=%b wr=%b data=%h, required ready=%b wr=%b data=%h",
                 $time, req_ready, fifo_wr_en, fifo_data_in, e_ready, e_wr, e_data);
      end
      n_checks++;
      if (act_regs() !== exp_regs()) begin
        n_errors++;
        $display("FAIL random_regs t=%0t: got %h required %h", $time, act_regs(), exp_regs());
      end
      tick();
    end
    req_valid = '0; fifo_full = 1'b0; fifo_overflow = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_drop();
    test_mid_reset();
    test_overflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin, burst-capable write arbiter that shares the single write port of the team's synchronous FIFO among NUM_REQ producers. Each producer presents data on a valid/ready handshake. The arbiter selects one owner, drives the FIFO's `wr_en`/`data_in` directly, and back-pressures on the FIFO's `full` flag. It also keeps transfer and stall counters and a sticky overflow error for the verification scoreboard and status registers.

## Interface
- NUM_REQ, 4, number of producers (2..8)
- FIFO_WIDTH, 16, data width, equal to the FIFO's FIFO_WIDTH
- MAX_BURST, 4, maximum consecutive transfers per grant (1..15)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-producer data valid
- req_data  in  NUM_REQ*FIFO_WIDTH  per-producer data; producer i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- req_ready  out  NUM_REQ  one-hot or zero; a transfer occurs when `req_valid[i] & req_ready[i]`
- fifo_full  in  1  FIFO full flag
- fifo_overflow  in  1  FIFO overflow flag
- fifo_wr_en  out  1  FIFO write enable
- fifo_data_in  out  FIFO_WIDTH  FIFO write data
- clr_err  in  1  synchronous clear of `overflow_err`
- busy  out  1  registered; high in state BUSY
- owner_id  out  $clog2(NUM_REQ)  registered current owner; valid when `busy` is high
- xfer_total  out  16  transfers accepted; wraps modulo 2^16
- stall_cycles  out  16  cycles in which the owner or candidate is valid and `fifo_full` is high; saturates at 0xFFFF
- overflow_err  out  1  sticky; set when `fifo_overflow` is high

## Operation
- States:
  - IDLE: no owner.
  - BUSY: owner and burst count are held in registers.
- IDLE:
  - The candidate is the first requester with `req_valid` set, searching from `rr_ptr` upward with wrap-around.
  - If a candidate exists and `!fifo_full`: `req_ready[cand]=1`, `fifo_wr_en=1`, `fifo_data_in=req_data[cand]`. The transfer is accepted this cycle.
  - After the transfer, if MAX_BURST==1: stay in IDLE and set `rr_ptr=cand+1`.
  - Otherwise, go to BUSY with `owner=cand` and `burst_cnt=1`.
  - If a candidate exists but `fifo_full` is high: no ready, stay in IDLE, `rr_ptr` is unchanged, and `stall_cycles` increments.
- BUSY:
  - `req_ready[owner] = !fifo_full`. All other ready bits are 0.
  - If the owner is valid and `!fifo_full`: transfer, then `burst_cnt++`. When the new count equals MAX_BURST, go to IDLE with `rr_ptr=owner+1`.
  - If the owner is valid and `fifo_full` is high: hold the grant, no transfer, `stall_cycles++`. Stalls do not count toward the burst.
  - If the owner is not valid: go to IDLE with `rr_ptr=owner+1`. There is no transfer that cycle, and other requesters are not served that cycle.
- `fifo_wr_en` is never asserted while `fifo_full` is high.
- When `fifo_wr_en` is low, `fifo_data_in` is 0.
- `rr_ptr` arithmetic is modulo NUM_REQ.
- `xfer_total` increments by 1 on every transfer.
- `overflow_err`:
  - Set on any cycle in which `fifo_overflow` is high.
  - Cleared by `clr_err` only when `fifo_overflow` is low in the same cycle. Set wins over clear.
- Reset, whenever `rst_n` is low, including mid-burst:
  - State returns to IDLE; `rr_ptr`, `owner_id`, `burst_cnt`, counters and `overflow_err` are all 0.
  - Any partial burst is abandoned.
  - `req_ready`, `fifo_wr_en` and `fifo_data_in` are 0 while `rst_n` is low.

## Timing
- `req_ready`, `fifo_wr_en` and `fifo_data_in` are combinational from the registered state, `req_valid`, `req_data` and `fifo_full`. This gives zero-cycle acceptance latency.
- There is no combinational path from any input to `busy`, `owner_id`, the counters or `overflow_err`. These update on the rising edge after the triggering cycle.
- The FIFO samples `fifo_wr_en` on the same edge at which the arbiter updates its state.
- The FIFO's `full` reflects that write one cycle later. The arbiter relies only on the `fifo_full` presented in the current cycle.
- Maximum sustained throughput is 1 transfer per cycle.
- A grant ended because the owner dropped valid costs 1 idle cycle.
- Worst-case wait for a continuously valid requester is (NUM_REQ-1)*MAX_BURST transfers, plus any stall cycles.

## Test plan
- Reset, then assert only `req_valid[2]` with data 0xA5A5 for 10 cycles, FIFO never full -> 10 transfers:
  - `owner_id` is 2 during each burst, and grants are released every 4 transfers.
  - `xfer_total=10`, and every `fifo_data_in` equals 0xA5A5.
- Hold all 4 requesters valid continuously with `fifo_full=0` -> grant order is 0,0,0,0,1,1,1,1,2,... in bursts of 4, with `fifo_wr_en` high every cycle.
- Raise `fifo_full` for 5 cycles mid-burst while owner 1 holds `burst_cnt=2` ->
  - `fifo_wr_en` is 0 and `req_ready` is 0 for those cycles.
  - `stall_cycles` increases by 5, owner 1 is retained, and 2 more transfers follow.
- Owner 3 drops valid after 1 transfer while requester 0 is valid -> one idle cycle, then requester 0 is granted (`rr_ptr` wrapped to 0).
- Assert `rst_n` low mid-burst -> all outputs are 0 immediately; after release, arbitration restarts at requester 0.
- Pulse `fifo_overflow` -> `overflow_err` is 1 on the next cycle. A `clr_err` issued in the same cycle as a new `fifo_overflow` leaves it set; `clr_err` alone clears it.
